alu_arbiter: RTL and testbench

Shares the single combinational ALU datapath between two requesters, for example the execute stage and a debug/address-generation port. Each requester uses a valid/ready handshake. Arbitration is round-robin. The block registers the ALU operands, captures the result and the Z/N flags one cycle later, and returns them on that requester's response channel. It sits between the requesters and the ALU instance and is the only driver of the ALU's select, A and B inputs.

---
 rtl/alu_arbiter_if.sv | 55 +++++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of both requester channels, both response channels and the ALU hookup.
// The arbiter takes the slave view; requesters, responders and the ALU sit on the master view.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [SEL_W-1:0] req0_select;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [SEL_W-1:0] req1_select;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [SEL_W-1:0] alu_select;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic             alu_z;
  logic             alu_n;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_z;
  logic             rsp0_n;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_z;
  logic             rsp1_n;

  modport slave (
    input  req0_valid, req0_select, req0_a, req0_b,
    input  req1_valid, req1_select, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_select, alu_a, alu_b,
    input  alu_out, alu_z, alu_n,
    output rsp0_valid, rsp0_result, rsp0_z, rsp0_n,
    output rsp1_valid, rsp1_result, rsp1_z, rsp1_n,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_select, req0_a, req0_b,
    output req1_valid, req1_select, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_select, alu_a, alu_b,
    output alu_out, alu_z, alu_n,
    input  rsp0_valid, rsp0_result, rsp0_z, rsp0_n,
    input  rsp1_valid, rsp1_result, rsp1_z, rsp1_n,
    output rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Each op runs IDLE (accept) -> EXEC (ALU settles, capture) -> RESP (hold until owner takes it).
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             owner_q, owner_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             grant_s;
  logic             grant_id_s;
  logic             owner_rdy_s;
  logic             req0_ready_s;
  logic             req1_ready_s;

  // Arbitration: a lone requester wins outright, a tie goes to the round-robin pointer.
  always_comb begin
    grant_s     = bus.req0_valid | bus.req1_valid;
    grant_id_s  = (bus.req0_valid & bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
    owner_rdy_s = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
  end

  // Next-state, operand/result capture and accept strobes.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    alu_sel_d    = alu_sel_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    result_d     = result_q;
    z_d          = z_q;
    n_d          = n_q;
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          // Ready is suppressed while reset is held so no op is claimed and then dropped.
          req0_ready_s = ~grant_id_s & rst_n;
          req1_ready_s = grant_id_s & rst_n;
          owner_d      = grant_id_s;
          alu_sel_d    = grant_id_s ? bus.req1_select : bus.req0_select;
          alu_a_d      = grant_id_s ? bus.req1_a : bus.req0_a;
          alu_b_d      = grant_id_s ? bus.req1_b : bus.req0_b;
          state_d      = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        result_d = bus.alu_out;
        z_d      = bus.alu_z;
        n_d      = bus.alu_n;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_rdy_s) begin
          rr_ptr_d = ~owner_q;
          state_d  = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 1'b0;
      owner_q   <= 1'b0;
      alu_sel_q <= {SEL_W{1'b0}};
      alu_a_q   <= {WIDTH{1'b0}};
      alu_b_q   <= {WIDTH{1'b0}};
      result_q  <= {WIDTH{1'b0}};
      z_q       <= 1'b0;
      n_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      alu_sel_q <= alu_sel_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      result_q  <= result_d;
      z_q       <= z_d;
      n_q       <= n_d;
    end
  end

  assign bus.req0_ready  = req0_ready_s;
  assign bus.req1_ready  = req1_ready_s;
  assign bus.alu_select  = alu_sel_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  // Both response buses carry the captured result; only the owner's valid rises.
  assign bus.rsp0_valid  = (state_q == RESP) & ~owner_q;
  assign bus.rsp1_valid  = (state_q == RESP) & owner_q;
  assign bus.rsp0_result = result_q;
  assign bus.rsp0_z      = z_q;
  assign bus.rsp0_n      = n_q;
  assign bus.rsp1_result = result_q;
  assign bus.rsp1_z      = z_q;
  assign bus.rsp1_n      = n_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an adder ALU stub; inputs change and outputs are
// sampled around the falling clock edge.
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int SEL_W = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [WIDTH-1:0] exp_res;
  logic             exp_g;

  alu_arbiter_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.alu_out = bus.alu_a + bus.alu_b;
  assign bus.alu_z   = (bus.alu_out == 32'd0);
  assign bus.alu_n   = bus.alu_out[WIDTH-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req0_valid  = 1'b0;
    bus.req0_select = 4'h0;
    bus.req0_a      = 32'd0;
    bus.req0_b      = 32'd0;
    bus.req1_valid  = 1'b0;
    bus.req1_select = 4'h0;
    bus.req1_a      = 32'd0;
    bus.req1_b      = 32'd0;
    bus.rsp0_ready  = 1'b0;
    bus.rsp1_ready  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".alu_sel"}, 64'(bus.alu_select), 64'd0);
    check({tag, ".alu_a"},   64'(bus.alu_a),      64'd0);
    check({tag, ".alu_b"},   64'(bus.alu_b),      64'd0);
    check({tag, ".rsp0_v"},  64'(bus.rsp0_valid), 64'd0);
    check({tag, ".rsp1_v"},  64'(bus.rsp1_valid), 64'd0);
    check({tag, ".result"},  64'(bus.rsp0_result), 64'd0);
    check({tag, ".z"},       64'(bus.rsp0_z),     64'd0);
    check({tag, ".n"},       64'(bus.rsp1_n),     64'd0);
    check({tag, ".rdy0"},    64'(bus.req0_ready), 64'd0);
    check({tag, ".rdy1"},    64'(bus.req1_ready), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    clear_inputs();
    do_reset();

    // 1. Single op from requester 0.
    bus.req0_valid = 1'b1; bus.req0_select = 4'h3; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
    #1;
    check("t1.rdy0_T", 64'(bus.req0_ready), 64'd1);
    check("t1.rdy1_T", 64'(bus.req1_ready), 64'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    check("t1.alu_a",   64'(bus.alu_a),      64'd5);
    check("t1.alu_b",   64'(bus.alu_b),      64'd7);
    check("t1.alu_sel", 64'(bus.alu_select), 64'd3);
    check("t1.rsp0_T1", 64'(bus.rsp0_valid), 64'd0);
    @(negedge clk);
    check("t1.rsp0_T2", 64'(bus.rsp0_valid),  64'd1);
    check("t1.result",  64'(bus.rsp0_result), 64'd12);
    check("t1.z",       64'(bus.rsp0_z),      64'd0);
    check("t1.n",       64'(bus.rsp0_n),      64'd0);
    check("t1.rsp1_v",  64'(bus.rsp1_valid),  64'd0);
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    check("t1.rsp0_drop", 64'(bus.rsp0_valid), 64'd0);

    // 2. Contention right after reset: requester 0 first, then requester 1.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
    bus.req1_valid = 1'b1; bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 32'd0;
    #1;
    check("t2.rdy0", 64'(bus.req0_ready), 64'd1);
    check("t2.rdy1", 64'(bus.req1_ready), 64'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    check("t2.rdy1_exec", 64'(bus.req1_ready), 64'd0);
    @(negedge clk);
    check("t2.rsp0_v",   64'(bus.rsp0_valid),  64'd1);
    check("t2.result0",  64'(bus.rsp0_result), 64'd3);
    check("t2.rdy1_rsp", 64'(bus.req1_ready),  64'd0);
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;
    check("t2.rdy1_idle", 64'(bus.req1_ready), 64'd1);
    check("t2.rsp0_drop", 64'(bus.rsp0_valid), 64'd0);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("t2.rsp1_v",   64'(bus.rsp1_valid),  64'd1);
    check("t2.rsp0_v2",  64'(bus.rsp0_valid),  64'd0);
    check("t2.result1",  64'(bus.rsp1_result), 64'hFFFF_FFFF);
    check("t2.n1",       64'(bus.rsp1_n),      64'd1);
    check("t2.z1",       64'(bus.rsp1_z),      64'd0);
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp1_ready = 1'b0;

    // 3. Fairness: both valid for six ops, responses taken at once.
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'h100; bus.req0_b = 32'd1;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h200; bus.req1_b = 32'd2;
    for (int i = 0; i < 6; i++) begin
      exp_g = 1'(i % 2);
      #1;
      check($sformatf("t3.rdy0_op%0d", i), 64'(bus.req0_ready), 64'(!exp_g));
      check($sformatf("t3.rdy1_op%0d", i), 64'(bus.req1_ready), 64'(exp_g));
      exp_res = exp_g ? (bus.req1_a + bus.req1_b) : (bus.req0_a + bus.req0_b);
      @(negedge clk);
      if (exp_g) bus.req1_a = bus.req1_a + 32'h10;
      else       bus.req0_a = bus.req0_a + 32'h10;
      @(negedge clk);
      check($sformatf("t3.rspv_op%0d", i),
            64'(exp_g ? bus.rsp1_valid : bus.rsp0_valid), 64'd1);
      check($sformatf("t3.res_op%0d", i), 64'(bus.rsp0_result), 64'(exp_res));
      @(negedge clk);
    end
    clear_inputs();

    // 4. Backpressure from requester 1; requester 0 waits, its rsp_ready is ignored.
    bus.req1_valid = 1'b1; bus.req1_select = 4'h5; bus.req1_a = 32'd3; bus.req1_b = 32'hFFFF_FFFD;
    #1;
    check("t4.rdy1", 64'(bus.req1_ready), 64'd1);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd9; bus.req0_b = 32'd1;
    #1;
    check("t4.rdy0_exec", 64'(bus.req0_ready), 64'd0);
    @(negedge clk);
    bus.rsp0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t4.rsp1_v%0d", i),  64'(bus.rsp1_valid),  64'd1);
      check($sformatf("t4.res%0d", i),     64'(bus.rsp1_result), 64'd0);
      check($sformatf("t4.z%0d", i),       64'(bus.rsp1_z),      64'd1);
      check($sformatf("t4.rdy0_%0d", i),   64'(bus.req0_ready),  64'd0);
      check($sformatf("t4.rsp0_v%0d", i),  64'(bus.rsp0_valid),  64'd0);
      @(negedge clk);
    end
    bus.rsp1_ready = 1'b1;
    #1;
    check("t4.rsp1_v_hs", 64'(bus.rsp1_valid), 64'd1);
    @(negedge clk);
    bus.rsp1_ready = 1'b0;
    bus.rsp0_ready = 1'b0;
    #1;
    check("t4.rsp1_drop", 64'(bus.rsp1_valid), 64'd0);
    check("t4.rdy0_idle", 64'(bus.req0_ready), 64'd1);

    // 5. Reset while requester 0's op is in EXEC.
    @(negedge clk);
    bus.req0_valid = 1'b0;
    check("t5.alu_a_exec", 64'(bus.alu_a), 64'd9);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("t5.mid");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t5.rsp0_none%0d", i), 64'(bus.rsp0_valid), 64'd0);
      check($sformatf("t5.rsp1_none%0d", i), 64'(bus.rsp1_valid), 64'd0);
    end
    bus.req1_valid = 1'b1; bus.req1_a = 32'h20; bus.req1_b = 32'h22;
    #1;
    check("t5.rdy1", 64'(bus.req1_ready), 64'd1);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("t5.rsp1_v",  64'(bus.rsp1_valid),  64'd1);
    check("t5.result",  64'(bus.rsp1_result), 64'h42);
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp1_ready = 1'b0;

    // 6. Pointer moves past requester 0 even when it was alone.
    bus.req0_valid = 1'b1; bus.req0_a = 32'd2; bus.req0_b = 32'd2;
    #1;
    check("t6.rdy0_solo", 64'(bus.req0_ready), 64'd1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("t6.result0", 64'(bus.rsp0_result), 64'd4);
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd6; bus.req0_b = 32'd0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd8; bus.req1_b = 32'h8000_0000;
    #1;
    check("t6.rdy1_first", 64'(bus.req1_ready), 64'd1);
    check("t6.rdy0_wait",  64'(bus.req0_ready), 64'd0);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("t6.rsp1_v",   64'(bus.rsp1_valid),  64'd1);
    check("t6.result1",  64'(bus.rsp1_result), 64'h8000_0008);
    check("t6.n1",       64'(bus.rsp1_n),      64'd1);
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp1_ready = 1'b0;
    #1;
    check("t6.rdy0_next", 64'(bus.req0_ready), 64'd1);
    @(negedge clk);
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
